// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice (two half adders plus an OR) processes
// one operand bit pair per cycle, LSB first. Optional carry-in via SERIAL_ADDER_CIN_EN.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_CIN_EN
    input  logic             Cin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);
    // Counter must stay at least one bit wide even when WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, ADD} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt;
    logic             carry_q;

    logic             p, g, s, pc, c_next;
    logic [WIDTH-1:0] res_next;
    logic             cin_init;

`ifdef SERIAL_ADDER_CIN_EN
    assign cin_init = Cin;
`else
    assign cin_init = 1'b0;
`endif

    half_adder u_ha0 (.a(a_q[0]), .b(b_q[0]), .s(p), .c(g));
    half_adder u_ha1 (.a(p),      .b(carry_q), .s(s), .c(pc));
    assign c_next = g | pc;

    // The new sum bit enters at the MSB; the concatenation form also covers WIDTH=1.
    assign res_next = WIDTH'({s, res_q} >> 1);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let the slice see half-updated operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            Sum     <= '0;
            Carry   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        res_q   <= '0;
                        carry_q <= cin_init;
                        cnt     <= CW'(WIDTH - 1);
                        busy    <= 1'b1;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    res_q   <= res_next;
                    carry_q <= c_next;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    cnt     <= cnt - 1'b1;
                    if (cnt == '0) begin
                        Sum   <= res_next;
                        Carry <= c_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
